// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode map, instruction field positions and
// the fetch-stage state encoding.
package sisc_pkg;

    localparam logic [3:0] NOOP   = 4'd0;
    localparam logic [3:0] LOD    = 4'd1;
    localparam logic [3:0] STR    = 4'd2;
    localparam logic [3:0] SWP    = 4'd3;
    localparam logic [3:0] BRA    = 4'd4;
    localparam logic [3:0] BRR    = 4'd5;
    localparam logic [3:0] BNE    = 4'd6;
    localparam logic [3:0] BNR    = 4'd7;
    localparam logic [3:0] ALU_OP = 4'd8;
    localparam logic [3:0] HLT    = 4'd15;

    localparam logic [3:0] AM_IMM = 4'd8;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int MM_HI  = 27;
    localparam int MM_LO  = 24;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_ERR  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sisc_fetch_unit_if.sv
// Instruction-memory port of the fetch stage; master is the fetch unit,
// slave is the instruction memory.
interface sisc_fetch_unit_if #(
    parameter int PC_W = 16,
    parameter int IR_W = 32
) ();

    // im_req rises together with a registered im_addr and stays high, with
    // im_addr stable, until the first cycle im_ack is sampled high; im_rdata
    // is only meaningful in that cycle. im_ack outside a request is ignored.
    logic            im_req;
    logic [PC_W-1:0] im_addr;
    logic            im_ack;
    logic [IR_W-1:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_rdata
    );

endinterface

// File: rtl/sisc_br_addr.sv
// Branch target adder: relative (pc+1+imm) or absolute (imm), modulo 2^PC_W.
module sisc_br_addr #(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] imm,
    input  logic            br_sel,
    output logic [PC_W-1:0] target
);

    localparam logic [PC_W-1:0] ONE = PC_W'(1);

    logic [PC_W-1:0] base;

    assign base   = br_sel ? '0 : pc + ONE;
    assign target = base + imm;

endmodule

// File: rtl/sisc_fetch_unit.sv
// PC register and request/acknowledge instruction fetch into the IR, with
// a sticky timeout flag when memory never acknowledges.
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int PC_W        = 16,
    parameter int IR_W        = 32,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic             pc_rst,
    input  logic             pc_write,
    input  logic             pc_sel,
    input  logic             br_sel,
    input  logic             ir_load,
    sisc_fetch_unit_if.master im,
    output logic [PC_W-1:0]  pc_out,
    output logic [IR_W-1:0]  ir_out,
    output logic [3:0]       opcode,
    output logic [3:0]       mm,
    output logic             ir_valid,
    output logic             fetch_busy,
    output logic             fetch_err,
    output fetch_state_t     state_dbg
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);

    fetch_state_t    state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [PC_W-1:0] im_addr_q;
    logic            im_req_q;
    logic [PC_W-1:0] imm;
    logic [PC_W-1:0] target;

    logic start_fetch, capture, abort, timeout, wait_tick;

    assign imm = PC_W'(ir_out[IMM_HI:IMM_LO]);

    sisc_br_addr #(.PC_W(PC_W)) u_br_addr (
        .pc     (pc_out),
        .imm    (imm),
        .br_sel (br_sel),
        .target (target)
    );

    always_ff @(posedge clk) begin
        if (rst_f) state <= FS_IDLE;
        else       state <= state_nxt;
    end

    // pc_rst aborts an outstanding fetch but never leaves ERR; the
    // timeout fires on the ACK_TIMEOUT-th unacknowledged WAIT cycle.
    always_comb begin
        state_nxt   = state;
        start_fetch = 1'b0;
        capture     = 1'b0;
        abort       = 1'b0;
        timeout     = 1'b0;
        wait_tick   = 1'b0;
        case (state)
            FS_IDLE: begin
                if (ir_load && !pc_rst) begin
                    start_fetch = 1'b1;
                    state_nxt   = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (pc_rst) begin
                    abort     = 1'b1;
                    state_nxt = FS_IDLE;
                end else if (im.im_ack) begin
                    capture   = 1'b1;
                    state_nxt = FS_IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    wait_tick = 1'b1;
                    timeout   = 1'b1;
                    state_nxt = FS_ERR;
                end else begin
                    wait_tick = 1'b1;
                end
            end
            FS_ERR:  state_nxt = FS_ERR;
            default: state_nxt = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            pc_out    <= '0;
            ir_out    <= '0;
            im_addr_q <= '0;
            im_req_q  <= 1'b0;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (pc_rst)        pc_out <= '0;
            else if (pc_write) pc_out <= pc_sel ? target : pc_out + PC_ONE;

            ir_valid <= capture;

            // Fetch address is the PC before any same-cycle pc_write.
            if (start_fetch) begin
                im_addr_q <= pc_out;
                im_req_q  <= 1'b1;
                wait_cnt  <= '0;
            end else if (wait_tick) begin
                wait_cnt  <= wait_cnt + CNT_ONE;
            end

            if (capture) ir_out <= im.im_rdata;
            if (capture || abort || timeout) im_req_q <= 1'b0;
            if (timeout) fetch_err <= 1'b1;
        end
    end

    assign im.im_req   = im_req_q;
    assign im.im_addr  = im_addr_q;
    assign opcode      = ir_out[OPC_HI:OPC_LO];
    assign mm          = ir_out[MM_HI:MM_LO];
    assign fetch_busy  = (state == FS_WAIT);
    assign state_dbg   = state;

endmodule

// File: doc/sisc_fetch_unit.md
Name: sisc_fetch_unit

Overview:
Program-counter and instruction-fetch stage that consumes the control FSM's pc_rst, pc_write, pc_sel, br_sel and ir_load strobes. It produces the opcode and mm fields back to the FSM. It owns the PC register and computes relative and absolute branch targets. It runs a request/acknowledge fetch from variable-latency instruction memory into the instruction register, reports busy to the FSM for stalling, and flags memory timeouts.

Parameters:
PC_W, 16, PC and instruction-memory address width
IR_W, 32, instruction width
ACK_TIMEOUT, 15, maximum cycles in WAIT before the fetch error is raised

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_f  in  1  synchronous, active-high reset
pc_rst  in  1  clear PC to 0 and abort any fetch
pc_write  in  1  load next-PC value into PC
pc_sel  in  1  0: next PC = PC+1; 1: next PC = branch target
br_sel  in  1  0: target = PC+1+imm (relative); 1: target = 0+imm (absolute)
ir_load  in  1  start instruction fetch from current PC
im_ack  in  1  instruction memory data-valid
im_rdata  in  IR_W  instruction memory read data
im_req  out  1  fetch request, held until ack
im_addr  out  PC_W  fetch address, registered
pc_out  out  PC_W  current PC
ir_out  out  IR_W  instruction register
opcode  out  4  ir_out[31:28]
mm  out  4  ir_out[27:24]
ir_valid  out  1  one-cycle pulse when ir_out is updated
fetch_busy  out  1  high while a fetch is outstanding
fetch_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst_f=1 at edge):
  - pc_out, ir_out, im_addr and timeout counter go to 0; ir_out=0 decodes as NOOP.
  - im_req, ir_valid and fetch_err go to 0; state goes to IDLE.
  - rst_f overrides every other input.
- Branch target: imm = ir_out[15:0]; base = br_sel ? 0 : pc_out+1; target = base+imm. Addition is modulo 2^PC_W with carry discarded, so 0xFFFF+1 wraps to 0x0000.
- PC update, priority pc_rst > pc_write:
  - pc_rst: pc_out <= 0.
  - pc_write: pc_out <= pc_sel ? target : pc_out+1.
  - Otherwise pc_out holds.
- Fetch FSM states: IDLE, WAIT, ERR.
  - IDLE, ir_load=1: im_addr <= pc_out, the value before any same-cycle pc_write. Then im_req <= 1, counter <= 0, go to WAIT.
  - WAIT, im_ack=1: ir_out <= im_rdata, ir_valid <= 1 for exactly one cycle, im_req <= 0, go to IDLE.
  - WAIT, no ack: counter increments. When counter reaches ACK_TIMEOUT: im_req <= 0, fetch_err <= 1, go to ERR.
  - ERR: terminal until rst_f. ir_load, im_ack and pc_rst do not leave ERR. PC updates still apply.
- fetch_busy = (state==WAIT), combinational from state. The FSM must not advance past fetch while it is high.
- ir_load while WAIT or ERR: ignored. No second request, no error.
- im_ack while IDLE (late ack after an abort): ignored, and ir_out is unchanged.
- pc_rst during WAIT: im_req <= 0, return to IDLE, ir_out unchanged, no ir_valid. fetch_err is not cleared.
- ir_load and pc_write in the same cycle: the fetch uses the old PC and the PC updates. This is the normal fetch-state behaviour.
- ir_load and pc_rst in the same cycle: pc_rst wins, and no fetch starts.
- Minimum latency: ir_load at cycle N, ack at N+1, ir_valid and new ir_out at N+2.

Decomposition:
- Shared package sisc_pkg:
  - opcode constants (NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15) and AM_IMM=8
  - field positions OPC_HI/LO=31/28, MM_HI/LO=27/24, IMM_HI/LO=15/0
  - fetch state encoding
- One sub-module, sisc_br_addr: purely combinational target adder with inputs pc, imm, br_sel and output target.

Test Plan:
- Reset then ir_load=1 with im_ack on the next cycle, im_rdata=0x4000_0012 -> im_addr=0x0000; ir_valid pulses once; opcode=4, mm=0, pc_out=1 after the pc_write in the same cycle.
- pc_out=0x0010, imm=0x0005, pc_sel=1, br_sel=0, pc_write -> pc_out=0x0016. Same case with br_sel=1 -> 0x0005. pc_out=0xFFFF, br_sel=0, imm=0 -> 0x0000 (wrap).
- ir_load, then im_ack held low 5 cycles, then high -> im_req high for exactly 6 cycles; fetch_busy high throughout; a second ir_load mid-wait produces no new request.
- ir_load with no ack -> after ACK_TIMEOUT=15 cycles im_req=0 and fetch_err=1. Then ir_load and pc_rst are ignored by the FSM; only rst_f clears the error.
- pc_rst mid-WAIT, then im_ack and im_rdata=0xDEAD_BEEF -> pc_out=0, im_req drops, ir_out unchanged, no ir_valid.
- pc_rst and pc_write in the same cycle, pc_out=0x0042 -> pc_out=0x0000.
